uart_tx_arbiter: RTL and testbench

Round-robin controller that shares one uart_tx serializer between NUM_REQ byte producers. It selects one pending requester, launches the byte with a one-cycle start pulse, and tracks the serializer's busy flag until the frame completes. It supports optional per-requester locking so multi-byte packets go out back-to-back. It sits between the producer FIFOs and the uart_tx block, and flags a launch that the serializer never acknowledges.

---
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ producers.
// Supports per-requester packet locking and flags launches that never see busy.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_lock,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       err_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic          lock_hold;
  logic [CW-1:0] cnt;
  logic [IW-1:0] sel;
  int            j;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + IW'(1);
  endfunction

  // Lowest offset from rr_ptr wins; a held lock overrides while still valid.
  always_comb begin
    sel = rr_ptr;
    j   = 0;
    if (lock_hold && req_valid[grant_id]) begin
      sel = grant_id;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        j = (int'(rr_ptr) + k) % NUM_REQ;
        if (req_valid[j]) sel = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      req_ack     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
      rr_ptr      <= '0;
      lock_hold   <= 1'b0;
      cnt         <= '0;
    end else begin
      tx_start    <= 1'b0;
      req_ack     <= '0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (lock_hold && !req_valid[grant_id])
            lock_hold <= 1'b0;
          if (!tx_busy && |req_valid) begin
            tx_start <= 1'b1;
            tx_data  <= req_data[{sel, 3'b000} +: 8];
            req_ack  <= NUM_REQ'(1) << sel;
            grant_id <= sel;
            cnt      <= '0;
            active   <= 1'b1;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
            // Byte is dropped; move on so one dead launch cannot stall others.
            err_timeout <= 1'b1;
            rr_ptr      <= nxt(grant_id);
            lock_hold   <= 1'b0;
            active      <= 1'b0;
            state       <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state     <= IDLE;
            active    <= 1'b0;
            lock_hold <= req_lock[grant_id];
            if (!req_lock[grant_id])
              rr_ptr <= nxt(grant_id);
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table plus multi-cycle sequences,
// with a launch scoreboard and a behavioural uart_tx busy model.
module tb_uart_tx_arbiter;

  localparam int FRAME = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_lock = '0;
  logic [3:0]  req_ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_lock(req_lock),
    .req_ack(req_ack),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy rises the edge after start, stays FRAME cycles
  logic model_busy = 1'b0;
  int   mcnt = 0;
  int   busy_mode = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      mcnt <= 0;
    end else if (tx_start) begin
      model_busy <= 1'b1;
      mcnt <= FRAME;
    end else if (model_busy) begin
      if (mcnt == 1) model_busy <= 1'b0;
      mcnt <= mcnt - 1;
    end
  end

  assign tx_busy = (busy_mode == 2) ? 1'b1 :
                   (busy_mode == 1) ? 1'b0 : model_busy;

  typedef struct {
    logic [1:0] id;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] lock;
    logic [7:0] d0;
    logic [1:0] id;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  logic prev_busy = 1'b0;
  int   fall_cyc = 0;
  bit   have_fall = 0;
  bit   gap_chk = 0;
  bit   err_allowed = 0;
  int   starts = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ack_sync",
          {30'd0, $onehot0(req_ack), ((req_ack != 4'd0) == tx_start)},
          32'd3);
      if (err_timeout && !err_allowed)
        chk("unexpected_err", 32'd1, 32'd0);
      if (tx_start) begin
        starts++;
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_id", 32'(grant_id), 32'(e.id));
          chk("tx_data", 32'(tx_data), 32'(e.dat));
          chk("req_ack", 32'(req_ack), 32'(4'd1 << e.id));
        end
        if (gap_chk && have_fall)
          chk("launch_gap", 32'(cyc - fall_cyc), 32'd2);
      end
      if (!gap_chk) begin
        have_fall = 0;
      end else if (prev_busy && !tx_busy) begin
        have_fall = 1;
        fall_cyc = cyc;
      end
    end
    prev_busy = tx_busy;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_lock = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input string nm);
    bit seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      seen = tx_start;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      done = !active;
    end
    chk("idle_timeout", 32'(active), 32'd0);
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] dat);
    exp_t x;
    x.id = id;
    x.dat = dat;
    exp_q.push_back(x);
  endtask

  int  s0;
  int  lc;
  bit  seen;

  initial begin
    tbl[0] = '{4'b0001, 4'b0000, 8'hA5, 2'd0, 8'hA5};
    tbl[1] = '{4'b1111, 4'b0000, 8'h10, 2'd1, 8'h11};
    tbl[2] = '{4'b0011, 4'b0000, 8'h10, 2'd0, 8'h10};
    tbl[3] = '{4'b1000, 4'b0000, 8'h10, 2'd3, 8'h13};
    tbl[4] = '{4'b0110, 4'b0000, 8'h10, 2'd1, 8'h11};
    tbl[5] = '{4'b0110, 4'b0100, 8'h10, 2'd2, 8'h12};
    tbl[6] = '{4'b0111, 4'b0000, 8'h10, 2'd2, 8'h12};
    tbl[7] = '{4'b0011, 4'b0000, 8'h10, 2'd0, 8'h10};
    tbl[8] = '{4'b0100, 4'b0100, 8'h10, 2'd2, 8'h12};
    tbl[9] = '{4'b0011, 4'b0000, 8'h10, 2'd1, 8'h11};

    // reset state and vector table (single launches)
    busy_mode = 0;
    do_reset();
    chk("reset_state",
        {16'd0, tx_start, tx_data, req_ack, grant_id, active, err_timeout},
        32'd0);
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].valid;
      req_lock = tbl[i].lock;
      req_data = {8'h13, 8'h12, 8'h11, tbl[i].d0};
      push(tbl[i].id, tbl[i].dat);
      wait_start("vec_start");
      req_valid = '0;
      @(negedge clk);
      chk("start_pulse", {27'd0, tx_start, req_ack}, 32'd0);
      chk("active_mid", 32'(active), 32'd1);
      wait_idle();
    end

    // all requesters held valid: fair rotation with 2-edge gaps
    do_reset();
    req_data = 32'h13121110;
    req_valid = 4'b1111;
    gap_chk = 1;
    push(2'd0, 8'h10);
    push(2'd1, 8'h11);
    push(2'd2, 8'h12);
    push(2'd3, 8'h13);
    push(2'd0, 8'h10);
    for (int i = 0; i < 5; i++) wait_start("rr_start");
    req_valid = '0;
    gap_chk = 0;
    wait_idle();

    // lock keeps requester 1 for three bytes
    do_reset();
    req_valid = 4'b0011;
    push(2'd0, 8'h10);
    push(2'd1, 8'h11);
    push(2'd1, 8'h11);
    push(2'd1, 8'h11);
    push(2'd0, 8'h10);
    wait_start("lock_s0");
    wait_start("lock_s1");
    req_lock = 4'b0010;
    wait_start("lock_s2");
    wait_start("lock_s3");
    req_lock = 4'b0000;
    wait_start("lock_s4");
    req_valid = '0;
    wait_idle();

    // serializer never raises busy
    do_reset();
    busy_mode = 1;
    err_allowed = 1;
    req_valid = 4'b0011;
    push(2'd0, 8'h10);
    push(2'd1, 8'h11);
    wait_start("to_start");
    lc = cyc;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = err_timeout;
    end
    chk("err_seen", 32'(seen), 32'd1);
    chk("err_latency", 32'(cyc - lc), 32'd8);
    chk("idle_after_err", 32'(active), 32'd0);
    wait_start("to_relaunch");
    chk("err_pulse", 32'(err_timeout), 32'd0);
    req_valid = '0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = err_timeout;
    end
    chk("err_second", 32'(seen), 32'd1);
    @(negedge clk);
    err_allowed = 0;
    busy_mode = 0;

    // busy held from reset blocks launch
    busy_mode = 2;
    do_reset();
    req_valid = 4'b0100;
    s0 = starts;
    repeat (10) @(negedge clk);
    chk("busy_blocks", 32'(starts - s0), 32'd0);
    push(2'd2, 8'h12);
    busy_mode = 0;
    wait_start("busy_release");
    req_valid = '0;
    wait_idle();

    // reset during WAIT_DONE
    do_reset();
    req_valid = 4'b0001;
    push(2'd0, 8'h10);
    wait_start("mid_s0");
    req_valid = '0;
    wait_idle();
    req_valid = 4'b0010;
    push(2'd1, 8'h11);
    wait_start("mid_s1");
    req_valid = '0;
    repeat (2) @(negedge clk);
    chk("in_wait_done", {30'd0, active, tx_busy}, 32'd3);
    busy_mode = 2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_reset_out",
        {16'd0, tx_start, tx_data, req_ack, grant_id, active, err_timeout},
        32'd0);
    req_valid = 4'b0011;
    s0 = starts;
    repeat (8) @(negedge clk);
    chk("mid_no_launch", 32'(starts - s0), 32'd0);
    push(2'd0, 8'h10);
    busy_mode = 0;
    wait_start("mid_relaunch");
    req_valid = '0;
    wait_idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
